// File: rtl/normalization_sequencer_pkg.sv
// Shared types and default widths for the normalization sequencer.
// Pulled in by the sequencer, its interface and its testbench.
package norm_seq_pkg;

    localparam int ADDR_WIDTH_DEF  = 8;
    localparam int SHIFT_WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD      = 3'd1,
        WAIT_RD = 3'd2,
        WR      = 3'd3,
        DONE    = 3'd4
    } state_t;

endpackage

// File: rtl/normalization_sequencer_if.sv
// Layer-controller, accumulator-read and output-write signals of the sequencer.
// The master side drives the requests; the sequencer sits on the slave side.
interface normalization_sequencer_if #(
    parameter int ADDR_WIDTH  = norm_seq_pkg::ADDR_WIDTH_DEF,
    parameter int SHIFT_WIDTH = norm_seq_pkg::SHIFT_WIDTH_DEF
);
    logic                   Start;
    logic                   Abort;
    logic [SHIFT_WIDTH-1:0] ShiftIn;
    logic [ADDR_WIDTH:0]    RowCount;
    logic [ADDR_WIDTH-1:0]  RdBase;
    logic [ADDR_WIDTH-1:0]  WrBase;
    logic [SHIFT_WIDTH-1:0] ShiftAmmount;
    logic                   AccRdEn;
    logic [ADDR_WIDTH-1:0]  AccRdAddr;
    logic                   AccRdValid;
    logic                   OutValid;
    logic [ADDR_WIDTH-1:0]  OutAddr;
    logic                   OutReady;
    logic                   Busy;
    logic                   Done;

    modport master (
        output Start, Abort, ShiftIn, RowCount, RdBase, WrBase, AccRdValid, OutReady,
        input  ShiftAmmount, AccRdEn, AccRdAddr, OutValid, OutAddr, Busy, Done
    );

    modport slave (
        input  Start, Abort, ShiftIn, RowCount, RdBase, WrBase, AccRdValid, OutReady,
        output ShiftAmmount, AccRdEn, AccRdAddr, OutValid, OutAddr, Busy, Done
    );

endinterface

// File: rtl/normalization_sequencer.sv
// Drains one tile of accumulator rows through Normalization into the output buffer,
// one row at a time, with variable-latency reads and back-pressured writes.
//
// state   | meaning
// IDLE    | waiting for Start; config latched when a Start is accepted
// RD      | one-cycle accumulator read request for row idx
// WAIT_RD | waiting for AccRdValid
// WR      | OutValid held with OutAddr until OutReady
// DONE    | one-cycle Done pulse, then back to IDLE
module normalization_sequencer
    import norm_seq_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int SHIFT_WIDTH = SHIFT_WIDTH_DEF
) (
    input logic                      Clk,
    input logic                      Rst_n,
    normalization_sequencer_if.slave bus
);

    state_t                 state;
    logic [ADDR_WIDTH:0]    idx;
    logic [ADDR_WIDTH:0]    row_count;
    logic [ADDR_WIDTH-1:0]  rd_base;
    logic [ADDR_WIDTH-1:0]  wr_base;

    logic [SHIFT_WIDTH-1:0] shift_q;
    logic                   acc_rd_en;
    logic [ADDR_WIDTH-1:0]  acc_rd_addr;
    logic                   out_valid;
    logic [ADDR_WIDTH-1:0]  out_addr;
    logic                   busy;
    logic                   done;

    // idx is one bit wider than the address so a full 2^ADDR_WIDTH-row tile terminates.
    logic [ADDR_WIDTH:0]    idx_inc;
    logic                   last_row;

    assign idx_inc  = idx + 1'b1;
    assign last_row = (idx_inc == row_count);

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            row_count   <= '0;
            rd_base     <= '0;
            wr_base     <= '0;
            shift_q     <= '0;
            acc_rd_en   <= 1'b0;
            acc_rd_addr <= '0;
            out_valid   <= 1'b0;
            out_addr    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            acc_rd_en <= 1'b0;
            done      <= 1'b0;

            // Abort drops the row in flight without a write handshake; the shift stays latched.
            if (bus.Abort) begin
                state     <= IDLE;
                out_valid <= 1'b0;
                busy      <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.Start) begin
                            shift_q   <= bus.ShiftIn;
                            row_count <= bus.RowCount;
                            rd_base   <= bus.RdBase;
                            wr_base   <= bus.WrBase;
                            idx       <= '0;
                            if (bus.RowCount == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state       <= RD;
                                acc_rd_en   <= 1'b1;
                                acc_rd_addr <= bus.RdBase;
                                busy        <= 1'b1;
                            end
                        end
                    end
                    RD: begin
                        state <= WAIT_RD;
                    end
                    WAIT_RD: begin
                        if (bus.AccRdValid) begin
                            state     <= WR;
                            out_valid <= 1'b1;
                            out_addr  <= wr_base + idx[ADDR_WIDTH-1:0];
                        end
                    end
                    WR: begin
                        if (bus.OutReady) begin
                            out_valid <= 1'b0;
                            if (last_row) begin
                                state <= DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state       <= RD;
                                idx         <= idx_inc;
                                acc_rd_en   <= 1'b1;
                                acc_rd_addr <= rd_base + idx_inc[ADDR_WIDTH-1:0];
                            end
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                    end
                    default: begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ShiftAmmount = shift_q;
    assign bus.AccRdEn      = acc_rd_en;
    assign bus.AccRdAddr    = acc_rd_addr;
    assign bus.OutValid     = out_valid;
    assign bus.OutAddr      = out_addr;
    assign bus.Busy         = busy;
    assign bus.Done         = done;

endmodule

// File: tb/tb_normalization_sequencer.sv
// Directed testbench for normalization_sequencer: tile walks, stalls, wrap, ignored Start,
// abort and asynchronous reset, checked with immediate assertions against hand-computed values.
module tb_normalization_sequencer;
    import norm_seq_pkg::*;

    localparam int AW = 8;
    localparam int SW = 8;

    logic Clk   = 1'b0;
    logic Rst_n = 1'b0;

    normalization_sequencer_if #(.ADDR_WIDTH(AW), .SHIFT_WIDTH(SW)) bus ();

    normalization_sequencer #(.ADDR_WIDTH(AW), .SHIFT_WIDTH(SW)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    logic [AW-1:0] rd_addrs [0:299];
    logic [AW-1:0] wr_addrs [0:299];
    int n_rd, n_wr, n_done, done_at, busy_cyc, shift_err, stable_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Call at posedge+1; the Start is accepted at the next edge.
    task automatic start_tile(input logic [SW-1:0] sh, input logic [AW:0] rc,
                              input logic [AW-1:0] rb, input logic [AW-1:0] wb);
        bus.ShiftIn  = sh;
        bus.RowCount = rc;
        bus.RdBase   = rb;
        bus.WrBase   = wb;
        bus.Start    = 1'b1;
    endtask

    // Cycle cyc is observed #1 after the cyc-th edge following start_tile.
    task automatic run(input int vdelay, input int rdelay, input int max_cyc,
                       input logic [SW-1:0] exp_shift, input int glitch_row, input int abort_row);
        int vcnt = 0;
        int rcnt = 0;
        int abort_pending = 0;
        logic prev_ov = 1'b0;
        logic [AW-1:0] held = '0;
        n_rd = 0; n_wr = 0; n_done = 0; done_at = -1;
        busy_cyc = 0; shift_err = 0; stable_err = 0;
        for (int cyc = 1; cyc <= max_cyc; cyc++) begin
            @(posedge Clk);
            #1;
            bus.Start = 1'b0;
            bus.Abort = 1'b0;
            if (abort_pending != 0) begin
                bus.Abort     = 1'b1;
                abort_pending = 0;
            end
            if (bus.ShiftAmmount !== exp_shift) shift_err++;
            if (bus.Busy === 1'b1) busy_cyc++;
            if (bus.Done === 1'b1) begin
                if (done_at < 0) done_at = cyc;
                n_done++;
            end
            if (bus.AccRdEn === 1'b1) begin
                rd_addrs[n_rd] = bus.AccRdAddr;
                if (n_rd == abort_row) abort_pending = 1;
                n_rd++;
                vcnt = vdelay;
            end else if (vcnt > 0) begin
                vcnt--;
            end
            bus.AccRdValid = (vcnt == 0);
            if (bus.OutValid === 1'b1) begin
                if (!prev_ov) begin
                    wr_addrs[n_wr] = bus.OutAddr;
                    held = bus.OutAddr;
                    if (n_wr == glitch_row) begin
                        bus.Start    = 1'b1;
                        bus.ShiftIn  = 8'd3;
                        bus.RowCount = 9'd1;
                    end
                    n_wr++;
                    rcnt = rdelay;
                end else begin
                    if (bus.OutAddr !== held) stable_err++;
                    if (rcnt > 0) rcnt--;
                end
                bus.OutReady = (rcnt == 0);
            end else begin
                bus.OutReady = (rdelay == 0);
            end
            prev_ov = (bus.OutValid === 1'b1);
            if (done_at > 0 && cyc >= done_at + 2) break;
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_shift"},  bus.ShiftAmmount, 0);
        check({tag, "_rden"},   bus.AccRdEn, 0);
        check({tag, "_rdaddr"}, bus.AccRdAddr, 0);
        check({tag, "_ovalid"}, bus.OutValid, 0);
        check({tag, "_oaddr"},  bus.OutAddr, 0);
        check({tag, "_busy"},   bus.Busy, 0);
        check({tag, "_done"},   bus.Done, 0);
    endtask

    logic [AW-1:0] exp_wrap [0:3];

    initial begin
        exp_wrap[0] = 8'hFE; exp_wrap[1] = 8'hFF; exp_wrap[2] = 8'h00; exp_wrap[3] = 8'h01;
        bus.Start = 1'b0; bus.Abort = 1'b0; bus.ShiftIn = '0; bus.RowCount = '0;
        bus.RdBase = '0; bus.WrBase = '0; bus.AccRdValid = 1'b0; bus.OutReady = 1'b0;

        repeat (2) @(posedge Clk);
        #1;
        check_outputs_zero("reset");
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;

        // 4 rows, no stalls
        start_tile(8'd6, 9'd4, 8'h10, 8'h80);
        run(0, 0, 40, 8'd6, -1, -1);
        check("t1_done_at", done_at, 13);
        check("t1_n_done", n_done, 1);
        check("t1_n_rd", n_rd, 4);
        check("t1_n_wr", n_wr, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_rd%0d", i), rd_addrs[i], 32'h10 + i);
            check($sformatf("t1_wr%0d", i), wr_addrs[i], 32'h80 + i);
        end
        check("t1_shift_err", shift_err, 0);
        check("t1_busy_cyc", busy_cyc, 12);

        // 2 rows, read delayed 3 cycles, write stalled 4 cycles per row
        start_tile(8'd1, 9'd2, 8'h20, 8'h40);
        run(3, 4, 60, 8'd1, -1, -1);
        check("t2_done_at", done_at, 19);
        check("t2_n_done", n_done, 1);
        check("t2_n_rd", n_rd, 2);
        check("t2_n_wr", n_wr, 2);
        check("t2_stable_err", stable_err, 0);
        check("t2_rd1", rd_addrs[1], 32'h21);
        check("t2_wr0", wr_addrs[0], 32'h40);
        check("t2_wr1", wr_addrs[1], 32'h41);

        // empty tile
        start_tile(8'd4, 9'd0, 8'h33, 8'h44);
        run(0, 0, 10, 8'd4, -1, -1);
        check("t3_done_at", done_at, 1);
        check("t3_n_done", n_done, 1);
        check("t3_n_rd", n_rd, 0);
        check("t3_n_wr", n_wr, 0);
        check("t3_busy_cyc", busy_cyc, 0);
        check("t3_shift_err", shift_err, 0);

        // read address wrap
        start_tile(8'd2, 9'd4, 8'hFE, 8'h00);
        run(0, 0, 40, 8'd2, -1, -1);
        check("t4_done_at", done_at, 13);
        for (int i = 0; i < 4; i++) check($sformatf("t4_rd%0d", i), rd_addrs[i], exp_wrap[i]);

        // full 256-row tile, write address wrap
        start_tile(8'd8, 9'd256, 8'h00, 8'hC0);
        run(0, 0, 800, 8'd8, -1, -1);
        check("t5_done_at", done_at, 769);
        check("t5_n_done", n_done, 1);
        check("t5_n_rd", n_rd, 256);
        check("t5_n_wr", n_wr, 256);
        check("t5_wr63", wr_addrs[63], 32'hFF);
        check("t5_wr64", wr_addrs[64], 32'h00);
        check("t5_wr255", wr_addrs[255], 32'hBF);
        check("t5_rd255", rd_addrs[255], 32'hFF);

        // Start during WR of row 1 must be ignored
        start_tile(8'd5, 9'd3, 8'h50, 8'h60);
        run(0, 0, 40, 8'd5, 1, -1);
        check("t6_done_at", done_at, 10);
        check("t6_n_done", n_done, 1);
        check("t6_n_wr", n_wr, 3);
        check("t6_shift_err", shift_err, 0);
        check("t6_shift_after", bus.ShiftAmmount, 5);
        check("t6_busy_after", bus.Busy, 0);

        // Abort in WAIT_RD of row 2
        start_tile(8'd7, 9'd4, 8'h00, 8'h10);
        run(2, 0, 20, 8'd7, -1, 2);
        check("t7_done_at", done_at, 32'hFFFF_FFFF);
        check("t7_n_done", n_done, 0);
        check("t7_n_rd", n_rd, 3);
        check("t7_n_wr", n_wr, 2);
        check("t7_busy_after", bus.Busy, 0);
        check("t7_ovalid_after", bus.OutValid, 0);
        check("t7_shift_after", bus.ShiftAmmount, 7);

        // asynchronous reset mid-tile
        start_tile(8'd9, 9'd4, 8'h01, 8'h90);
        run(0, 0, 5, 8'd9, -1, -1);
        check("t8_busy_pre", bus.Busy, 1);
        check("t8_oaddr_pre", bus.OutAddr, 32'h90);
        Rst_n = 1'b0;
        #1;
        check_outputs_zero("t8_rst");
        @(posedge Clk);
        #1;
        Rst_n = 1'b1;
        @(posedge Clk);
        #1;
        check("t8_shift_post", bus.ShiftAmmount, 0);

        // fresh tile after reset
        start_tile(8'd2, 9'd2, 8'h30, 8'h31);
        run(0, 0, 20, 8'd2, -1, -1);
        check("t9_done_at", done_at, 7);
        check("t9_n_done", n_done, 1);
        check("t9_rd0", rd_addrs[0], 32'h30);
        check("t9_rd1", rd_addrs[1], 32'h31);
        check("t9_wr0", wr_addrs[0], 32'h31);
        check("t9_wr1", wr_addrs[1], 32'h32);
        check("t9_shift_err", shift_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/normalization_sequencer.md
# normalization_sequencer

Control sequencer that drains a tile of accumulator rows through the combinational Normalization stage into the output activation buffer. It latches a per-tile shift amount, walks the accumulator and output address ranges one row at a time, and handshakes with the variable-latency accumulator read port and the back-pressured output write port. It sits between the layer controller (Start/Done) and the Normalization datapath, which is instantiated beside it by the parent.

## Interface
Parameters:
- ADDR_WIDTH, 8, accumulator and output buffer row address width.
- SHIFT_WIDTH, 8, width of the shift amount driven to Normalization.

Ports:
- Clk  in  1  single clock, all state on rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Start  in  1  tile start request, sampled only in IDLE.
- Abort  in  1  synchronous abort, priority over Start.
- ShiftIn  in  SHIFT_WIDTH  shift amount, latched on accepted Start.
- RowCount  in  ADDR_WIDTH+1  rows in tile (0..2^ADDR_WIDTH), latched on accepted Start.
- RdBase  in  ADDR_WIDTH  first accumulator row, latched on accepted Start.
- WrBase  in  ADDR_WIDTH  first output row, latched on accepted Start.
- ShiftAmmount  out  SHIFT_WIDTH  latched shift, to Normalization.
- AccRdEn  out  1  accumulator read request, one-cycle pulse per row.
- AccRdAddr  out  ADDR_WIDTH  accumulator row address.
- AccRdValid  in  1  read data valid; buffer holds data until next AccRdEn.
- OutValid  out  1  normalized row valid at output buffer.
- OutAddr  out  ADDR_WIDTH  output row address.
- OutReady  in  1  output buffer accepts row.
- Busy  out  1  tile in progress.
- Done  out  1  one-cycle tile completion pulse.

## Operation
- States: IDLE, RD, WAIT_RD, WR, DONE.
- IDLE: Start=1 and RowCount!=0 -> RD; Start=1 and RowCount==0 -> DONE; latch ShiftIn, RowCount, RdBase, WrBase; clear row index.
- RD: AccRdEn=1, AccRdAddr=RdBase+idx -> WAIT_RD unconditionally.
- WAIT_RD: wait for AccRdValid=1 -> WR. AccRdValid outside WAIT_RD ignored.
- WR: OutValid=1, OutAddr=WrBase+idx; held stable until OutReady=1. On OutReady: idx==RowCount-1 -> DONE, else idx+1 -> RD.
- DONE: Done=1 for exactly one cycle -> IDLE.
- Abort=1 in any state -> IDLE next cycle; no Done; OutValid may drop without handshake; latched ShiftAmmount retained.
- Start in any state other than IDLE ignored.
- Addresses are ADDR_WIDTH modulo sums: base+idx wraps past 2^ADDR_WIDTH-1 to 0.
- Row index is ADDR_WIDTH+1 bits, so RowCount = 2^ADDR_WIDTH is valid.
- ShiftAmmount changes only on accepted Start; stable for the whole tile.

## Timing
- Reset: state IDLE; ShiftAmmount, AccRdEn, AccRdAddr, OutValid, OutAddr, Busy, Done all 0; latched config 0.
- Start accepted at edge N -> AccRdEn=1 during cycle N+1.
- Busy=1 in RD, WAIT_RD, WR; 0 in IDLE and DONE.
- Per row minimum 3 cycles (RD, WAIT_RD with same-cycle AccRdValid, WR with OutReady high).
- Tile of R rows, zero stalls: Done asserts 3R+1 cycles after Start edge.
- RowCount==0: Done asserts in cycle N+1; no AccRdEn or OutValid.
- OutValid and OutReady in the same first WR cycle: handshake completes that cycle.
- Outputs are Moore decodes of registered state and counters; no input-to-output combinational paths.
- Rst_n asserted mid-tile: all outputs return to reset values immediately (asynchronous).

## Structure
- Package norm_seq_pkg: state enum typedef (IDLE, RD, WAIT_RD, WR, DONE), SHIFT_WIDTH default constant.
- Single module, no sub-module; Normalization is instantiated by the parent and fed ShiftAmmount from this block.

## Test plan
- RowCount=4, RdBase=0x10, WrBase=0x80, ShiftIn=6, AccRdValid same cycle as request, OutReady tied 1 -> AccRdAddr 0x10..0x13, OutAddr 0x80..0x83, ShiftAmmount=6, Done at cycle 13 after Start.
- RowCount=2, AccRdValid delayed 3 cycles, OutReady low 4 cycles per row -> OutValid/OutAddr stable throughout stall, exactly 2 AccRdEn pulses, single Done.
- RowCount=0 -> Done one cycle after Start, Busy never high, no AccRdEn or OutValid.
- RdBase=0xFE, RowCount=4 -> AccRdAddr sequence 0xFE, 0xFF, 0x00, 0x01; RowCount=256 -> 256 writes then Done.
- Start pulsed during WR of row 1 with ShiftIn=3 while tile ShiftIn=5 -> ignored, ShiftAmmount stays 5, row count unchanged.
- Abort in WAIT_RD of row 2, then Rst_n low mid-tile in a second run -> IDLE, no Done; reset drives all outputs to 0 asynchronously, new Start proceeds normally.
